// File: rtl/pc_fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory req/ack, decode valid/ready
// and the redirect input from PC-select.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [29:0] if_pc;
    logic        if_ready;
    logic        redir_valid;
    logic [29:0] redir_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, if_ready, redir_valid, redir_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, if_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: owns the fetch PC, sequences imem requests,
// hands instructions to decode and squashes wrong-path fetches.
module pc_fetch_ctrl #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t      state;
    logic [29:0] pc;
    logic [29:0] pend_pc;
    logic        kill;

    // Single FSM; every output is registered so that if_ready and
    // redir_valid never reach imem_req or if_valid combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RST;
            pc            <= RESET_PC;
            pend_pc       <= RESET_PC;
            kill          <= 1'b0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
            bus.if_valid  <= 1'b0;
            bus.if_instr  <= 32'h0;
            bus.if_pc     <= 30'h0;
        end else begin
            case (state)
                RST: begin
                    state         <= FETCH;
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= pc;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (!kill && !bus.redir_valid) begin
                            bus.if_instr  <= bus.imem_rdata;
                            bus.if_pc     <= pc;
                            bus.if_valid  <= 1'b1;
                            bus.imem_req  <= 1'b0;
                            bus.imem_addr <= pc + 30'd1;
                            pc            <= pc + 30'd1;
                            state         <= OUT;
                        end else begin
                            // Wrong-path data: refetch from the newest target.
                            pc            <= bus.redir_valid ? bus.redir_pc
                                                             : pend_pc;
                            bus.imem_addr <= bus.redir_valid ? bus.redir_pc
                                                             : pend_pc;
                            kill          <= 1'b0;
                        end
                    end else if (bus.redir_valid) begin
                        // Request cannot be withdrawn; mark it for discard.
                        kill    <= 1'b1;
                        pend_pc <= bus.redir_pc;
                    end
                end
                OUT: begin
                    if (bus.redir_valid) begin
                        pc            <= bus.redir_pc;
                        bus.imem_addr <= bus.redir_pc;
                        bus.imem_req  <= 1'b1;
                        bus.if_valid  <= 1'b0;
                        state         <= FETCH;
                    end else if (bus.if_ready) begin
                        bus.imem_addr <= pc;
                        bus.imem_req  <= 1'b1;
                        bus.if_valid  <= 1'b0;
                        state         <= FETCH;
                    end
                end
                default: begin
                    state        <= RST;
                    bus.imem_req <= 1'b0;
                    bus.if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with hand-computed expectations.
module tb_pc_fetch_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.RESET_PC(30'h0000_0C00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req),  32'h0);
        chk({tag, "_addr"},  32'(bus.imem_addr), 32'h0C00);
        chk({tag, "_valid"}, 32'(bus.if_valid),  32'h0);
        chk({tag, "_instr"}, bus.if_instr,       32'h0);
        chk({tag, "_pc"},    32'(bus.if_pc),     32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.if_ready    = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 30'h0;
        step();
        step();
        chk_reset("rst");

        // Sequential fetch, zero-wait memory, decode always ready.
        rst = 1'b0;
        bus.if_ready = 1'b1;
        step();
        for (int n = 0; n < 3; n++) begin
            chk("seq_req",   32'(bus.imem_req),  32'h1);
            chk("seq_addr",  32'(bus.imem_addr), 32'h0C00 + n);
            chk("seq_vlo",   32'(bus.if_valid),  32'h0);
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'h1000_0000 + n;
            step();
            bus.imem_ack = 1'b0;
            chk("seq_vhi",   32'(bus.if_valid),  32'h1);
            chk("seq_instr", bus.if_instr,       32'h1000_0000 + n);
            chk("seq_pc",    32'(bus.if_pc),     32'h0C00 + n);
            chk("seq_reqlo", 32'(bus.imem_req),  32'h0);
            step();
        end

        // Decode backpressure at C03.
        bus.if_ready   = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2000_0000;
        step();
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.if_valid), 32'h1);
            chk("bp_instr", bus.if_instr,      32'h2000_0000);
            chk("bp_pc",    32'(bus.if_pc),    32'h0C03);
            chk("bp_req",   32'(bus.imem_req), 32'h0);
            step();
        end
        bus.if_ready = 1'b1;
        step();
        chk("bp_next_req",  32'(bus.imem_req),  32'h1);
        chk("bp_next_addr", 32'(bus.imem_addr), 32'h0C04);

        // Redirect while holding an instruction with decode ready.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h3000_0000;
        step();
        bus.imem_ack = 1'b0;
        chk("ro_valid", 32'(bus.if_valid), 32'h1);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 30'h0000_0D40;
        step();
        bus.redir_valid = 1'b0;
        chk("ro_drop", 32'(bus.if_valid),  32'h0);
        chk("ro_req",  32'(bus.imem_req),  32'h1);
        chk("ro_addr", 32'(bus.imem_addr), 32'h0D40);

        // Two redirects during a wait-stated fetch; last one wins.
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 30'h0000_0E00;
        step();
        chk("ws_hold1", 32'(bus.imem_addr), 32'h0D40);
        bus.redir_pc = 30'h0000_0F00;
        step();
        bus.redir_valid = 1'b0;
        chk("ws_hold2", 32'(bus.imem_addr), 32'h0D40);
        chk("ws_req2",  32'(bus.imem_req),  32'h1);
        step();
        chk("ws_v3", 32'(bus.if_valid), 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack = 1'b0;
        chk("ws_valid", 32'(bus.if_valid),  32'h0);
        chk("ws_req",   32'(bus.imem_req),  32'h1);
        chk("ws_addr",  32'(bus.imem_addr), 32'h0F00);
        step();
        chk("ws_valid2", 32'(bus.if_valid), 32'h0);

        // Redirect in the same cycle as the ack.
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = 32'hBAD0_0001;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 30'h0000_0123;
        step();
        bus.imem_ack    = 1'b0;
        bus.redir_valid = 1'b0;
        chk("co_valid", 32'(bus.if_valid),  32'h0);
        chk("co_addr",  32'(bus.imem_addr), 32'h0123);
        chk("co_req",   32'(bus.imem_req),  32'h1);

        // Fetch 123, redirect to the top word, check wrap to zero.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0123_0123;
        step();
        bus.imem_ack = 1'b0;
        chk("wr_pc123", 32'(bus.if_pc), 32'h0123);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 30'h3FFF_FFFF;
        step();
        bus.redir_valid = 1'b0;
        chk("wr_addr_top", 32'(bus.imem_addr), 32'h3FFF_FFFF);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h4000_0000;
        step();
        bus.imem_ack = 1'b0;
        chk("wr_pc_top", 32'(bus.if_pc),    32'h3FFF_FFFF);
        chk("wr_instr",  bus.if_instr,      32'h4000_0000);
        step();
        chk("wr_addr0", 32'(bus.imem_addr), 32'h0);
        chk("wr_req0",  32'(bus.imem_req),  32'h1);

        // Reset while waiting for an ack, then a stale ack.
        step();
        rst = 1'b1;
        step();
        chk_reset("mrst");
        rst = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_0002;
        step();
        bus.imem_ack = 1'b0;
        chk("st_valid", 32'(bus.if_valid),  32'h0);
        chk("st_req",   32'(bus.imem_req),  32'h1);
        chk("st_addr",  32'(bus.imem_addr), 32'h0C00);
        step();
        chk("st_valid2", 32'(bus.if_valid), 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h5000_0000;
        step();
        bus.imem_ack = 1'b0;
        chk("st_pc",    32'(bus.if_pc),    32'h0C00);
        chk("st_instr", bus.if_instr,      32'h5000_0000);
        chk("st_vhi",   32'(bus.if_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
